// File: rtl/link_pkg.sv
// Frame field definitions and TX state encoding shared by the link sender and receiver.
// Pure definitions: no timing, no flow control.
package link_pkg;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_SYNC,
    TX_ID,
    TX_DATA,
    TX_PARITY,
    TX_GAP
  } txState_t;

  localparam logic [7:0] SYNC_PATTERN = 8'b0111_1110;
  localparam int         FRAME_DATA_W = 8;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/link_tx_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: first set request strictly above i_ptr, wrapping.
// Zero latency; no backpressure, the caller decides when to commit a winner.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]         i_req,
  input  logic [$clog2(N)-1:0] i_ptr,
  output logic [N-1:0]         o_grant_onehot,
  output logic [$clog2(N)-1:0] o_grant_idx
);

  localparam int IDX_W = $clog2(N);

  logic             w_found;
  logic [IDX_W-1:0] w_cand;

  // N is a power of two, so the candidate index wraps by plain truncation.
  always_comb begin
    w_found        = 1'b0;
    w_cand         = '0;
    o_grant_onehot = '0;
    o_grant_idx    = '0;
    for (int k = 1; k <= N; k++) begin
      w_cand = i_ptr + IDX_W'(k);
      if (!w_found && i_req[w_cand]) begin
        w_found                = 1'b1;
        o_grant_onehot[w_cand] = 1'b1;
        o_grant_idx            = w_cand;
      end
    end
  end

endmodule

// File: rtl/link_tx_scheduler.sv
// Round-robin serial framer: sync, ID, data, parity, gap; grant and first sync bit one cycle after arbitration.
// Producers hold req until their grant pulse; new requests wait until the line returns to idle.
module link_tx_scheduler
  import link_pkg::*;
#(
  parameter int         NUM_REQ  = 4,
  parameter logic [7:0] SYNC     = SYNC_PATTERN,
  parameter int         GAP_BITS = 2
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*8-1:0]       dataIn,
  output logic [NUM_REQ-1:0]         grant,
  output logic                       serialOut,
  output logic                       busy,
  output logic [$clog2(NUM_REQ)-1:0] curId,
  output logic                       frameDone
);

  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(max_int(FRAME_DATA_W, GAP_BITS));

  localparam logic [CNT_W-1:0] LAST_BYTE_BIT = CNT_W'(FRAME_DATA_W - 1);
  localparam logic [CNT_W-1:0] LAST_ID_BIT   = CNT_W'(ID_W - 1);
  localparam logic [CNT_W-1:0] LAST_GAP      = CNT_W'(GAP_BITS - 1);
  localparam logic [CNT_W-1:0] PENULT_GAP    = CNT_W'(GAP_BITS - 2);

  txState_t                  r_state;
  logic [CNT_W-1:0]          r_cnt;
  logic [ID_W-1:0]           r_ptr;
  logic [ID_W-1:0]           r_id;
  logic [FRAME_DATA_W-1:0]   r_data;
  logic [NUM_REQ-1:0]        r_grant;
  logic                      r_ser;
  logic                      r_busy;
  logic                      r_done;

  logic [NUM_REQ-1:0]        w_win_onehot;
  logic [ID_W-1:0]           w_win_idx;
  logic [FRAME_DATA_W-1:0]   w_win_data;
  logic [2:0]                w_byte_bit;
  logic [ID_W-1:0]           w_id_bit;
  logic                      w_parity;

  rr_arbiter #(
    .N (NUM_REQ)
  ) u_arb (
    .i_req          (req),
    .i_ptr          (r_ptr),
    .o_grant_onehot (w_win_onehot),
    .o_grant_idx    (w_win_idx)
  );

  // serialOut is registered, so each edge loads the bit for the *next* counter value.
  assign w_win_data = dataIn[FRAME_DATA_W*w_win_idx +: FRAME_DATA_W];
  assign w_byte_bit = 3'(FRAME_DATA_W - 2) - r_cnt[2:0];
  assign w_id_bit   = ID_W'(ID_W - 2) - r_cnt[ID_W-1:0];
  assign w_parity   = ^{r_id, r_data};

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= TX_IDLE;
      r_cnt   <= '0;
      r_ptr   <= ID_W'(NUM_REQ - 1);
      r_id    <= '0;
      r_data  <= '0;
      r_grant <= '0;
      r_ser   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_grant <= '0;
      r_done  <= 1'b0;
      case (r_state)
        TX_IDLE: begin
          r_ser  <= 1'b0;
          r_busy <= 1'b0;
          if (|req) begin
            r_state <= TX_SYNC;
            r_cnt   <= '0;
            r_grant <= w_win_onehot;
            r_id    <= w_win_idx;
            r_ptr   <= w_win_idx;
            r_data  <= w_win_data;
            r_ser   <= SYNC[7];
            r_busy  <= 1'b1;
          end
        end
        TX_SYNC: begin
          if (r_cnt == LAST_BYTE_BIT) begin
            r_state <= TX_ID;
            r_cnt   <= '0;
            r_ser   <= r_id[ID_W-1];
          end else begin
            r_cnt <= r_cnt + 1'b1;
            r_ser <= SYNC[w_byte_bit];
          end
        end
        TX_ID: begin
          if (r_cnt == LAST_ID_BIT) begin
            r_state <= TX_DATA;
            r_cnt   <= '0;
            r_ser   <= r_data[FRAME_DATA_W-1];
          end else begin
            r_cnt <= r_cnt + 1'b1;
            r_ser <= r_id[w_id_bit];
          end
        end
        TX_DATA: begin
          if (r_cnt == LAST_BYTE_BIT) begin
            r_state <= TX_PARITY;
            r_cnt   <= '0;
            r_ser   <= w_parity;
          end else begin
            r_cnt <= r_cnt + 1'b1;
            r_ser <= r_data[w_byte_bit];
          end
        end
        TX_PARITY: begin
          r_state <= TX_GAP;
          r_cnt   <= '0;
          r_ser   <= 1'b0;
          r_done  <= (GAP_BITS == 1);
        end
        TX_GAP: begin
          if (r_cnt == LAST_GAP) begin
            r_state <= TX_IDLE;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
          end else begin
            r_cnt  <= r_cnt + 1'b1;
            r_done <= (r_cnt == PENULT_GAP);
          end
        end
        default: begin
          r_state <= TX_IDLE;
          r_cnt   <= '0;
          r_ser   <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign grant     = r_grant;
  assign serialOut = r_ser;
  assign busy      = r_busy;
  assign curId     = r_id;
  assign frameDone = r_done;

endmodule

// File: doc/link_tx_scheduler.md
Name: link_tx_scheduler

Overview:
- Shares the single serial line between NUM_REQ byte producers.
- Round-robin arbitration picks one producer at a time.
- The winning byte is sent as a frame: sync byte, requester ID, data byte, even parity, then an idle gap.
- Sits in front of the serial line that feeds the Receiver; it replaces the single fixed-source Sender when several producers need the link.

Parameters:
NUM_REQ, 4, number of requesters; power of two, 2..8
SYNC, 8'b0111_1110, sync pattern sent MSB first at the start of every frame
GAP_BITS, 2, number of forced-0 bit times after the parity bit

Ports:
clock  input  1  system clock; all state changes on the rising edge
reset  input  1  asynchronous, active-high reset
req  input  NUM_REQ  req[i]=1 means requester i has a byte; held until grant[i]
dataIn  input  NUM_REQ*8  byte of requester i on dataIn[8*i+:8]; stable while req[i]=1
grant  output  NUM_REQ  one-hot, one-cycle pulse when requester i's byte is captured
serialOut  output  1  registered serial line; idle level 0
busy  output  1  1 from the grant cycle through the last gap bit
curId  output  ID_W  ID of the frame in flight (ID_W=$clog2(NUM_REQ)); holds last value when idle
frameDone  output  1  one-cycle pulse during the last gap bit

Behaviour:
- Reset (asynchronous, immediate):
  - serialOut=0, grant=0, busy=0, frameDone=0, curId=0.
  - State=IDLE, bit counter=0, RR pointer=NUM_REQ-1 (so req0 has top priority first).
- States: IDLE, SYNC, ID, DATA, PARITY, GAP.
- IDLE:
  - serialOut=0, busy=0.
  - If req!=0 at the edge, the winner is the first set bit searching upward from pointer+1 with wrap.
  - On that edge: latch dataIn of the winner; register grant[winner]=1 for exactly the next cycle; curId=winner; pointer=winner; go to SYNC.
- SYNC: 8 cycles, serialOut=SYNC[7..0], MSB first. The first SYNC bit appears in the same cycle grant is high.
- ID: ID_W cycles, curId MSB first.
- DATA: 8 cycles, latched byte MSB first.
- PARITY: 1 cycle; serialOut = XOR of all ID and data bits, so ones(ID,data,parity) is even.
- GAP: GAP_BITS cycles, serialOut=0. frameDone=1 in the last GAP cycle. Then go to IDLE.
- Frame period: 8+ID_W+8+1+GAP_BITS frame cycles plus 1 IDLE cycle. With defaults, back-to-back grant pulses are 22 cycles apart.
- busy=1 in every non-IDLE state.
- The latched byte is immune to dataIn or req changes after the grant.
- A requester that drops req before its grant is not served; no error is flagged.
- New requests arriving mid-frame wait; arbitration happens only in IDLE.
- Fairness: a requester holding req is served within NUM_REQ frames.
- Pointer wraps modulo NUM_REQ.
- Bit counter: width sufficient for max(8,GAP_BITS). It resets to 0 on every state change.
- Reset mid-frame: the frame is abandoned and serialOut drops to 0 immediately. A byte whose grant has already pulsed is lost; the requester is not re-granted.
- Never more than one grant bit is high; grant is 0 outside the cycle after IDLE arbitration.

Decomposition:
- Shared package link_pkg:
  - txState_t enum: IDLE, SYNC, ID, DATA, PARITY, GAP.
  - SYNC_PATTERN constant.
  - FRAME_DATA_W=8.
  - The same package is used by the Receiver for its sync/ID/parity field definitions.
- One sub-module, rr_arbiter:
  - Inputs: req, pointer. Outputs: one-hot winner, winner index.
  - Purely combinational.
  - Reusable for any future shared-resource arbitration in the codebase.

Test Plan:
- No req for 50 cycles -> serialOut=0, busy=0, grant=0 throughout.
- req[1]=1, dataIn byte1=8'hA5 -> grant=4'b0010 for one cycle. serialOut: 01111110, 01, 10100101, parity 1, then 00. frameDone pulses on the last 0. curId=1.
- req[0] and req[2] asserted together (bytes 8'h3C, 8'hFF), each dropped after its grant -> req0 frame first (ID 00, parity 0), then req2 frame (ID 10, parity 1). The second grant comes 22 cycles after the first.
- All four req held continuously -> grant order 0,1,2,3,0,1. Each grant is a one-hot single-cycle pulse.
- byte1 changed to 8'h00 one cycle after grant[1] (initial 8'hC3) -> serialOut still carries 11000011.
- Reset asserted during the DATA field -> serialOut=0 and busy=0 immediately, with no clock edge. After release, a pending req[3] is granted first from the reset pointer (priority 0,1,2,3).
